// File: rtl/prog_launcher_pkg.sv
// Shared types and default widths for the program launcher slice.
package launcher_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int CW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DRAIN,
    DONE
  } launch_state_t;

endpackage

// File: rtl/prog_launcher_if.sv
// Backdoor data-memory bus between the launcher (master) and the memory (slave).
interface prog_launcher_if
  import launcher_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          MemWrEn;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWrData;
  logic [DW-1:0] MemRdData;

  modport master (
    output MemWrEn,
    output MemAddr,
    output MemWrData,
    input  MemRdData
  );

  modport slave (
    input  MemWrEn,
    input  MemAddr,
    input  MemWrData,
    output MemRdData
  );

endinterface

// File: rtl/prog_launcher_sat_counter.sv
// Saturating up-counter with synchronous clear; AtMax flags Count == MAX.
module sat_counter
  import launcher_pkg::*;
#(
  parameter int CW  = CW_DEF,
  parameter int MAX = 16'hFFFF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Clear,
  input  logic          Enable,
  output logic [CW-1:0] Count,
  output logic          AtMax
);

  assign AtMax = (Count == CW'(MAX));

  // Count up while enabled, holding at MAX; clear has priority over counting.
  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      Count <= '0;
    end else if (Enable && !AtMax) begin
      Count <= Count + CW'(1);
    end
  end

endmodule

// File: rtl/prog_launcher.sv
// Host-side initiator for the processor Start/Ack run protocol: preloads data
// memory, pulses Start, times the run until Ack (or timeout), then streams
// result bytes back out of data memory.
// Optional feature: define LAUNCH_CHECKSUM_EN to build the XOR checksum of
// returned bytes; otherwise Checksum is tied to zero.
module prog_launcher
  import launcher_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int CW        = CW_DEF,
  parameter int START_LEN = 2,
  parameter int TIMEOUT   = 16'hFFFF
) (
  input  logic            Clk,
  input  logic            Reset,
  // run request
  input  logic            ReqValid,
  output logic            ReqReady,
  input  logic [AW-1:0]   ReqWrCnt,
  input  logic [AW-1:0]   ReqRdBase,
  input  logic [AW-1:0]   ReqRdCnt,
  // preload stream
  input  logic            InValid,
  output logic            InReady,
  input  logic [DW-1:0]   InData,
  // backdoor data-memory port
  prog_launcher_if.master Mem,
  // processor run control
  output logic            Start,
  input  logic            Ack,
  // result stream
  output logic            OutValid,
  input  logic            OutReady,
  output logic [DW-1:0]   OutData,
  // run status
  output logic            Done,
  output logic [CW-1:0]   Cycles,
  output logic            TimedOut,
  output logic [DW-1:0]   Checksum
);

  localparam int SW = (START_LEN > 1) ? $clog2(START_LEN) : 1;

  launch_state_t state, nextState;

  logic [AW-1:0] wrCnt;
  logic [AW-1:0] rdBase;
  logic [AW-1:0] rdCnt;
  logic [AW-1:0] idx;
  logic [AW-1:0] k;
  logic [SW-1:0] startCnt;
  logic [CW-1:0] runCount;
  logic          runAtMax;

  logic reqFire, inFire, outFire;
  logic lastIn, lastOut, startLast;
  logic timeoutHit, enterDone;

  assign reqFire    = (state == IDLE)  && ReqValid;
  assign inFire     = (state == LOAD)  && InValid;
  assign outFire    = (state == DRAIN) && OutReady;
  assign lastIn     = (idx == wrCnt - AW'(1));
  assign lastOut    = (k == rdCnt - AW'(1));
  assign startLast  = (startCnt == SW'(START_LEN - 1));
  assign timeoutHit = (state == RUN) && !Ack && runAtMax;
  assign enterDone  = (nextState == DONE) && (state != DONE);

  // Run-length counter: cleared while idle, counts RUN cycles with Ack low.
  sat_counter #(
    .CW (CW),
    .MAX(TIMEOUT)
  ) uRunCounter (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (state == IDLE),
    .Enable((state == RUN) && !Ack),
    .Count (runCount),
    .AtMax (runAtMax)
  );

  // State register; reset returns to IDLE from any state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; Ack takes priority over the timeout in the same cycle.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (ReqValid) nextState = (ReqWrCnt == '0) ? START : LOAD;
      LOAD:  if (InValid && lastIn) nextState = START;
      START: if (startLast) nextState = RUN;
      RUN: begin
        if (Ack) begin
          nextState = (rdCnt == '0) ? DONE : DRAIN;
        end else if (runAtMax) begin
          nextState = DONE;
        end
      end
      DRAIN: if (OutReady && lastOut) nextState = DONE;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Moore-style outputs, plus the same-cycle memory write and read path.
  always_comb begin
    ReqReady      = 1'b0;
    InReady       = 1'b0;
    Mem.MemWrEn   = 1'b0;
    Mem.MemAddr   = '0;
    Mem.MemWrData = '0;
    Start         = 1'b0;
    OutValid      = 1'b0;
    OutData       = '0;
    Done          = 1'b0;
    case (state)
      IDLE: ReqReady = 1'b1;
      LOAD: begin
        InReady       = 1'b1;
        Mem.MemWrEn   = InValid;
        Mem.MemAddr   = idx;
        Mem.MemWrData = InData;
      end
      START: Start = 1'b1;
      DRAIN: begin
        // Address wraps naturally at AW bits.
        Mem.MemAddr = rdBase + k;
        OutValid    = 1'b1;
        OutData     = Mem.MemRdData;
      end
      DONE: Done = 1'b1;
      default: ;
    endcase
  end

  // Request latch plus the preload, Start-length and drain index counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wrCnt    <= '0;
      rdBase   <= '0;
      rdCnt    <= '0;
      idx      <= '0;
      k        <= '0;
      startCnt <= '0;
    end else begin
      if (reqFire) begin
        wrCnt  <= ReqWrCnt;
        rdBase <= ReqRdBase;
        rdCnt  <= ReqRdCnt;
        idx    <= '0;
        k      <= '0;
      end
      if (inFire) begin
        idx <= idx + AW'(1);
      end
      if (outFire) begin
        k <= k + AW'(1);
      end
      startCnt <= (state == START) ? startCnt + SW'(1) : '0;
    end
  end

  // Run status is published on entry to DONE so it is valid while Done pulses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Cycles   <= '0;
      TimedOut <= 1'b0;
    end else if (enterDone) begin
      Cycles   <= runCount;
      TimedOut <= timeoutHit;
    end
  end

`ifdef LAUNCH_CHECKSUM_EN
  logic [DW-1:0] xorSum;

  // XOR of every returned byte, restarted by each accepted request.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      xorSum <= '0;
    end else if (reqFire) begin
      xorSum <= '0;
    end else if (outFire) begin
      xorSum <= xorSum ^ OutData;
    end
  end

  assign Checksum = xorSum;
`else
  assign Checksum = '0;
`endif

endmodule
